video_frontend: RTL and testbench
=================================

# video_frontend

Parametrised video capture and timing-measurement front end for the PCLK2x input domain. Registers the RGB+brightness pixel bus and both syncs, applies optional brightness scaling, and produces aligned pixel/sync outputs with horizontal/vertical position counters. Measures line length and frame height, and qualifies input mode stability with a lock state machine. Feeds the scanconverter and syncgen reference logic, and exposes `h_total`/`v_total`/`locked` to the CPU PIOs.

## Interface
- `COLOR_W`, 4, bits per R/G/B input component
- `BRI_W`, 4, bits of brightness (F) input
- `APPLY_BRI`, 1, 1: scale colour by brightness; 0: pass colour left-justified
- `SYNC_POL`, 0, 0: syncs active-low; 1: active-high
- `HCNT_W`, 12, horizontal counter width
- `VCNT_W`, 11, vertical counter width
- `H_TOL`, 2, allowed line-length deviation (pixels) while locked
- `LOCK_FRAMES`, 3, consecutive matching frames required to lock (≥1)

Ports:
- `PCLK` in 1: sole clock, all logic on rising edge
- `reset_n` in 1: asynchronous, active-low reset
- `R_in`, `G_in`, `B_in` in COLOR_W: pixel components
- `F_in` in BRI_W: brightness
- `HSYNC_in`, `VSYNC_in` in 1: input syncs, polarity per SYNC_POL
- `R_out`, `G_out`, `B_out` out COLOR_W+BRI_W: processed components
- `HSYNC_out`, `VSYNC_out` out 1: syncs normalised to active-high
- `hsync_edge`, `vsync_edge` out 1: one-cycle leading-edge strobes
- `hcnt` out HCNT_W: pixel index in line
- `vcnt` out VCNT_W: line index in frame
- `h_total` out HCNT_W: last measured line length, pixels
- `v_total` out VCNT_W: last measured frame height, lines
- `locked` out 1: input timing stable

## Operation
- Stage 1: register all inputs; syncs XORed with ~SYNC_POL so internal sync is active-high.
- Stage 2: colour processing, edge detection (stage-1 sync high and stage-2 sync low), counters; all outputs registered here.
- Colour, APPLY_BRI=1: out = C × (F+1), exact unsigned product, no truncation (max (2^COLOR_W−1)·2^BRI_W fits). APPLY_BRI=0: out = {C, BRI_W'b0}.
- hcnt: 0 on hsync_edge cycle, else +1; saturates at all-ones and sets internal `h_ovf` until next hsync_edge.
- vcnt: 0 on vsync_edge cycle; else +1 on hsync_edge; saturates at all-ones, sets `v_ovf`. Simultaneous hsync/vsync edge: vcnt=0 (vsync wins).
- h_total: on hsync_edge, latch previous hcnt+1 (i.e. period in clocks); not latched on the first hsync_edge after reset, nor if h_ovf (then keeps old value, counts as mismatch).
- v_total: on vsync_edge, latch previous vcnt+1; same first-edge/overflow rules.
- Lock FSM, states UNLOCKED, TRACK, LOCKED, match counter `mcnt`:
  - UNLOCKED: on first valid v_total latch → TRACK, mcnt=0.
  - TRACK: at each vsync_edge, if new v_total == previous v_total and no line mismatch in the frame, mcnt+1; on mcnt reaching LOCK_FRAMES → LOCKED; any mismatch → mcnt=0, stay TRACK.
  - Line mismatch: |new h_total − previous h_total| > H_TOL, or h_ovf, or v_ovf.
  - LOCKED: any line mismatch or v_total change → UNLOCKED immediately (same cycle as detection's register update), mcnt=0.
- `locked` = (state == LOCKED).

## Timing
- Reset values: all colour outputs 0, HSYNC_out/VSYNC_out 0, strobes 0, hcnt/vcnt 0, h_total/v_total 0, locked 0, FSM UNLOCKED, first-edge flags cleared.
- Latency input pin → outputs: 2 PCLK cycles for colour, syncs, strobes.
- hsync_edge asserted in the cycle HSYNC_out first reads 1; hcnt==0 that cycle; h_total updates the following cycle.
- `locked` rises the cycle after the LOCK_FRAMES-th matching vsync_edge; falls the cycle after the offending hsync/vsync_edge.
- Reset mid-frame: all state cleared asynchronously; measurement restarts, first subsequent edges are reference only.

## Test plan
- Defaults, R=0xF, F=0xF, G=0x3, F=0x0 → R_out=0xF0 for F=0xF; G_out=0x03 for F=0; 2-cycle latency checked.
- Active-low HSYNC every 512 clocks, VSYNC every 262 lines → h_total=512, v_total=262, locked rises after 3rd matching frame following first reference frame.
- Locked, one line lengthened to 515 → mismatch (>2), locked falls next cycle; 513 → locked held.
- HSYNC and VSYNC leading edges in same cycle → hcnt=0, vcnt=0, both strobes high.
- HSYNC removed for >4096 clocks (HCNT_W=12) → hcnt saturates 0xFFF, h_total unchanged, locked drops.
- reset_n pulsed mid-frame while locked → all outputs 0 immediately; relock requires full sequence again.

Source files
------------

// File: rtl/video_frontend.sv
// ---------------------------------------------------------------------------
// video_frontend
//
// Capture and timing-measurement front end for the PCLK2x input domain.
//
// Pipeline:
//   stage 1 : registers colour, brightness and both syncs. Syncs are
//             normalised to active-high here.
//   stage 2 : applies brightness scaling and detects sync leading edges.
//             Also runs the position counters. Every output is registered
//             in this stage.
//   measure : one cycle after each strobe, the line length / frame height
//             is latched into h_total / v_total and the lock FSM is updated.
//
// Ports:
//   PCLK, reset_n            clock (rising edge), async active-low reset
//   R_in, G_in, B_in, F_in   pixel components and brightness
//   HSYNC_in, VSYNC_in       input syncs, polarity selected by SYNC_POL
//   R_out, G_out, B_out      processed components (COLOR_W+BRI_W bits)
//   HSYNC_out, VSYNC_out     syncs, active-high, 2 cycles after the pins
//   hsync_edge, vsync_edge   one-cycle leading-edge strobes
//   hcnt, vcnt               pixel index in line / line index in frame
//   h_total, v_total         last measured line length / frame height
//   locked                   input timing qualified as stable
// ---------------------------------------------------------------------------
module video_frontend #(
    parameter int COLOR_W     = 4,
    parameter int BRI_W       = 4,
    parameter int APPLY_BRI   = 1,
    parameter int SYNC_POL    = 0,
    parameter int HCNT_W      = 12,
    parameter int VCNT_W      = 11,
    parameter int H_TOL       = 2,
    parameter int LOCK_FRAMES = 3
) (
    input  logic                       PCLK,
    input  logic                       reset_n,
    input  logic [COLOR_W-1:0]         R_in,
    input  logic [COLOR_W-1:0]         G_in,
    input  logic [COLOR_W-1:0]         B_in,
    input  logic [BRI_W-1:0]           F_in,
    input  logic                       HSYNC_in,
    input  logic                       VSYNC_in,
    output logic [COLOR_W+BRI_W-1:0]   R_out,
    output logic [COLOR_W+BRI_W-1:0]   G_out,
    output logic [COLOR_W+BRI_W-1:0]   B_out,
    output logic                       HSYNC_out,
    output logic                       VSYNC_out,
    output logic                       hsync_edge,
    output logic                       vsync_edge,
    output logic [HCNT_W-1:0]          hcnt,
    output logic [VCNT_W-1:0]          vcnt,
    output logic [HCNT_W-1:0]          h_total,
    output logic [VCNT_W-1:0]          v_total,
    output logic                       locked
);

    localparam int                OUT_W    = COLOR_W + BRI_W;
    localparam int                MC_W     = (LOCK_FRAMES < 2) ? 1 : $clog2(LOCK_FRAMES + 1);
    localparam logic              SYNC_INV = (SYNC_POL == 0);
    localparam logic [HCNT_W-1:0] HCNT_MAX = '1;
    localparam logic [VCNT_W-1:0] VCNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_TRACK    = 2'd1,
        ST_LOCKED   = 2'd2
    } lock_state_e;

    // The full product fits in OUT_W bits: (2^C-1)*2^B < 2^(C+B).
    function automatic logic [OUT_W-1:0] scale_colour(input logic [COLOR_W-1:0] c,
                                                      input logic [BRI_W:0]     f_inc);
        if (APPLY_BRI != 0) begin
            scale_colour = OUT_W'(c) * OUT_W'(f_inc);
        end else begin
            scale_colour = {c, {BRI_W{1'b0}}};
        end
    endfunction

    // ---------------- stage 1 ----------------
    logic [COLOR_W-1:0] r1_q, r1_d, g1_q, g1_d, b1_q, b1_d;
    logic [BRI_W-1:0]   f1_q, f1_d;
    logic               hs1_q, hs1_d, vs1_q, vs1_d;

    // ---------------- stage 2 ----------------
    logic [OUT_W-1:0]   r2_q, r2_d, g2_q, g2_d, b2_q, b2_d;
    logic               hs2_q, hs2_d, vs2_q, vs2_d;
    logic               hedge_q, hedge_d, vedge_q, vedge_d;
    logic [HCNT_W-1:0]  hcnt_q, hcnt_d;
    logic [VCNT_W-1:0]  vcnt_q, vcnt_d;
    logic               h_ovf_q, h_ovf_d, v_ovf_q, v_ovf_d;
    // Length of the line / frame that just closed, captured on the edge so
    // the measurement stage can use it while hcnt/vcnt already read 0.
    logic [HCNT_W-1:0]  hlen_q, hlen_d;
    logic               hlen_ovf_q, hlen_ovf_d;
    logic [VCNT_W-1:0]  vlen_q, vlen_d;
    logic               vlen_ovf_q, vlen_ovf_d;

    // ---------------- measurement / lock ----------------
    logic [HCNT_W-1:0]  h_total_q, h_total_d;
    logic [VCNT_W-1:0]  v_total_q, v_total_d;
    logic               h_seen_q, h_seen_d, v_seen_q, v_seen_d;
    logic               h_valid_q, h_valid_d, v_valid_q, v_valid_d;
    logic               line_mm_q, line_mm_d;
    lock_state_e        state_q, state_d;
    logic [MC_W-1:0]    mcnt_q, mcnt_d;

    // Combinational helpers
    logic [BRI_W:0]     f_inc;
    logic               h_at_max, v_at_max;
    logic               h_ovf_rise, v_ovf_rise;
    logic [HCNT_W-1:0]  h_diff;
    logic               h_line_mm, h_latch, line_mm_now;
    logic               v_latch, v_mm, frame_bad;
    logic [MC_W-1:0]    mcnt_inc;

    always_comb begin
        // stage 1: syncs are made active-high right at the pins
        r1_d  = R_in;
        g1_d  = G_in;
        b1_d  = B_in;
        f1_d  = F_in;
        hs1_d = HSYNC_in ^ SYNC_INV;
        vs1_d = VSYNC_in ^ SYNC_INV;

        // stage 2: colour
        f_inc = {1'b0, f1_q} + {{BRI_W{1'b0}}, 1'b1};
        r2_d  = scale_colour(r1_q, f_inc);
        g2_d  = scale_colour(g1_q, f_inc);
        b2_d  = scale_colour(b1_q, f_inc);

        // stage 2: syncs and leading edges
        hs2_d   = hs1_q;
        vs2_d   = vs1_q;
        hedge_d = hs1_q & ~hs2_q;
        vedge_d = vs1_q & ~vs2_q;

        // stage 2: horizontal counter, saturating
        h_at_max   = (hcnt_q == HCNT_MAX);
        h_ovf_rise = h_at_max & ~h_ovf_q & ~hedge_d;
        hcnt_d     = hcnt_q;
        h_ovf_d    = h_ovf_q;
        hlen_d     = hlen_q;
        hlen_ovf_d = hlen_ovf_q;
        if (hedge_d) begin
            hcnt_d     = '0;
            h_ovf_d    = 1'b0;
            hlen_d     = hcnt_q + HCNT_W'(1);
            // A count sitting at all-ones cannot represent its own length
            hlen_ovf_d = h_ovf_q | h_at_max;
        end else if (h_at_max) begin
            h_ovf_d = 1'b1;
        end else begin
            hcnt_d = hcnt_q + HCNT_W'(1);
        end

        // stage 2: vertical counter, saturating; vsync edge wins over hsync edge
        v_at_max   = (vcnt_q == VCNT_MAX);
        v_ovf_rise = hedge_d & v_at_max & ~v_ovf_q & ~vedge_d;
        vcnt_d     = vcnt_q;
        v_ovf_d    = v_ovf_q;
        vlen_d     = vlen_q;
        vlen_ovf_d = vlen_ovf_q;
        if (vedge_d) begin
            vcnt_d     = '0;
            v_ovf_d    = 1'b0;
            vlen_d     = vcnt_q + VCNT_W'(1);
            vlen_ovf_d = v_ovf_q | v_at_max;
        end else if (hedge_d) begin
            if (v_at_max) begin
                v_ovf_d = 1'b1;
            end else begin
                vcnt_d = vcnt_q + VCNT_W'(1);
            end
        end

        // measurement: acts in the cycle the strobes are visible
        h_diff      = (hlen_q >= h_total_q) ? (hlen_q - h_total_q) : (h_total_q - hlen_q);
        h_latch     = hedge_q & h_seen_q & ~hlen_ovf_q;
        h_line_mm   = hedge_q & h_seen_q &
                      (hlen_ovf_q | (h_valid_q & (h_diff > HCNT_W'(H_TOL))));
        // Overflow is flagged as soon as it happens so a vanished sync still
        // drops lock instead of waiting for an edge that may never come.
        line_mm_now = h_line_mm | h_ovf_rise | v_ovf_rise;

        v_latch     = vedge_q & v_seen_q & ~vlen_ovf_q;
        v_mm        = vedge_q & v_seen_q &
                      (vlen_ovf_q | (v_valid_q & (vlen_q != v_total_q)));
        frame_bad   = v_mm | line_mm_q | line_mm_now;

        h_total_d = h_latch ? hlen_q : h_total_q;
        h_valid_d = h_valid_q | h_latch;
        h_seen_d  = h_seen_q | hedge_q;
        v_total_d = v_latch ? vlen_q : v_total_q;
        v_valid_d = v_valid_q | v_latch;
        v_seen_d  = v_seen_q | vedge_q;

        // Per-frame line mismatch accumulator; a line closing on the vsync
        // edge belongs to the frame that is ending, so it is folded into
        // frame_bad above and the accumulator restarts clean.
        line_mm_d = vedge_q ? 1'b0 : (line_mm_q | line_mm_now);

        // lock FSM
        mcnt_inc = mcnt_q + MC_W'(1);
        state_d  = state_q;
        mcnt_d   = mcnt_q;
        case (state_q)
            ST_UNLOCKED: begin
                if (v_latch) begin
                    state_d = ST_TRACK;
                    mcnt_d  = '0;
                end
            end
            ST_TRACK: begin
                if (vedge_q) begin
                    if (!frame_bad && v_latch) begin
                        if (mcnt_inc == MC_W'(LOCK_FRAMES)) begin
                            state_d = ST_LOCKED;
                            mcnt_d  = '0;
                        end else begin
                            mcnt_d = mcnt_inc;
                        end
                    end else begin
                        mcnt_d = '0;
                    end
                end else if (line_mm_now) begin
                    mcnt_d = '0;
                end
            end
            ST_LOCKED: begin
                if (line_mm_now || v_mm) begin
                    state_d = ST_UNLOCKED;
                    mcnt_d  = '0;
                end
            end
            default: begin
                state_d = ST_UNLOCKED;
                mcnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge PCLK or negedge reset_n) begin
        if (!reset_n) begin
            r1_q       <= '0;
            g1_q       <= '0;
            b1_q       <= '0;
            f1_q       <= '0;
            hs1_q      <= 1'b0;
            vs1_q      <= 1'b0;
            r2_q       <= '0;
            g2_q       <= '0;
            b2_q       <= '0;
            hs2_q      <= 1'b0;
            vs2_q      <= 1'b0;
            hedge_q    <= 1'b0;
            vedge_q    <= 1'b0;
            hcnt_q     <= '0;
            vcnt_q     <= '0;
            h_ovf_q    <= 1'b0;
            v_ovf_q    <= 1'b0;
            hlen_q     <= '0;
            hlen_ovf_q <= 1'b0;
            vlen_q     <= '0;
            vlen_ovf_q <= 1'b0;
            h_total_q  <= '0;
            v_total_q  <= '0;
            h_seen_q   <= 1'b0;
            v_seen_q   <= 1'b0;
            h_valid_q  <= 1'b0;
            v_valid_q  <= 1'b0;
            line_mm_q  <= 1'b0;
            state_q    <= ST_UNLOCKED;
            mcnt_q     <= '0;
        end else begin
            r1_q       <= r1_d;
            g1_q       <= g1_d;
            b1_q       <= b1_d;
            f1_q       <= f1_d;
            hs1_q      <= hs1_d;
            vs1_q      <= vs1_d;
            r2_q       <= r2_d;
            g2_q       <= g2_d;
            b2_q       <= b2_d;
            hs2_q      <= hs2_d;
            vs2_q      <= vs2_d;
            hedge_q    <= hedge_d;
            vedge_q    <= vedge_d;
            hcnt_q     <= hcnt_d;
            vcnt_q     <= vcnt_d;
            h_ovf_q    <= h_ovf_d;
            v_ovf_q    <= v_ovf_d;
            hlen_q     <= hlen_d;
            hlen_ovf_q <= hlen_ovf_d;
            vlen_q     <= vlen_d;
            vlen_ovf_q <= vlen_ovf_d;
            h_total_q  <= h_total_d;
            v_total_q  <= v_total_d;
            h_seen_q   <= h_seen_d;
            v_seen_q   <= v_seen_d;
            h_valid_q  <= h_valid_d;
            v_valid_q  <= v_valid_d;
            line_mm_q  <= line_mm_d;
            state_q    <= state_d;
            mcnt_q     <= mcnt_d;
        end
    end

    assign R_out      = r2_q;
    assign G_out      = g2_q;
    assign B_out      = b2_q;
    assign HSYNC_out  = hs2_q;
    assign VSYNC_out  = vs2_q;
    assign hsync_edge = hedge_q;
    assign vsync_edge = vedge_q;
    assign hcnt       = hcnt_q;
    assign vcnt       = vcnt_q;
    assign h_total    = h_total_q;
    assign v_total    = v_total_q;
    assign locked     = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_video_frontend.sv
// ---------------------------------------------------------------------------
// tb_video_frontend
//
// Drives video_frontend (default parameters, active-low syncs) with short
// synthetic video: 40-clock lines, 10-line frames, 4-clock hsync pulse,
// vsync active for lines 0-1 so both leading edges coincide at frame start.
// Colour cycles through four directed vectors with hand-computed results.
// The driver pushes the expected pixel/sync/strobe word per cycle; a monitor
// pops one entry per clock once two are queued (2-cycle pipeline latency).
// Timing results (h_total, v_total, locked, hcnt) are checked directly at
// hand-derived cycle positions.
// ---------------------------------------------------------------------------
module tb_video_frontend;

    logic        PCLK;
    logic        reset_n;
    logic [3:0]  R_in, G_in, B_in, F_in;
    logic        HSYNC_in, VSYNC_in;
    logic [7:0]  R_out, G_out, B_out;
    logic        HSYNC_out, VSYNC_out, hsync_edge, vsync_edge;
    logic [11:0] hcnt, h_total;
    logic [10:0] vcnt, v_total;
    logic        locked;

    video_frontend #(
        .COLOR_W(4), .BRI_W(4), .APPLY_BRI(1), .SYNC_POL(0),
        .HCNT_W(12), .VCNT_W(11), .H_TOL(2), .LOCK_FRAMES(3)
    ) dut (
        .PCLK(PCLK), .reset_n(reset_n),
        .R_in(R_in), .G_in(G_in), .B_in(B_in), .F_in(F_in),
        .HSYNC_in(HSYNC_in), .VSYNC_in(VSYNC_in),
        .R_out(R_out), .G_out(G_out), .B_out(B_out),
        .HSYNC_out(HSYNC_out), .VSYNC_out(VSYNC_out),
        .hsync_edge(hsync_edge), .vsync_edge(vsync_edge),
        .hcnt(hcnt), .vcnt(vcnt), .h_total(h_total), .v_total(v_total),
        .locked(locked)
    );

    // ---------------- clock / reset ----------------
    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    // ---------------- bench state ----------------
    int          n_checks = 0;
    int          n_errors = 0;
    logic [27:0] exp_q[$];   // {R,G,B (8b each), HS, VS, hedge, vedge}
    bit          mon_en = 1'b0;
    bit          prev_hs = 1'b0, prev_vs = 1'b0;
    bit          hs_en = 1'b1, vs_en = 1'b1;
    int          px = 0, ln = 0, vcyc = 0;
    int          line_len = 40, frame_lines = 10;
    int          ovr_line = -1, ovr_len = 40;

    // {R,G,B,F} -> {R_out,G_out,B_out}, out = C*(F+1)
    logic [15:0] vec_in[4]  = '{16'hF30F, 16'hF310, 16'hA572, 16'h1E87};
    logic [23:0] vec_out[4] = '{24'hF03000, 24'h0F0301, 24'h1E0F15, 24'h087040};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver ----------------
    task automatic step();
        int          this_len;
        bit          hs_act, vs_act;
        logic [15:0] v;
        logic [23:0] o;
        this_len = (ln == ovr_line) ? ovr_len : line_len;
        hs_act   = hs_en && (px < 4);
        vs_act   = vs_en && (ln < 2);
        v        = vec_in[vcyc % 4];
        o        = vec_out[vcyc % 4];
        @(negedge PCLK);
        R_in     = v[15:12];
        G_in     = v[11:8];
        B_in     = v[7:4];
        F_in     = v[3:0];
        HSYNC_in = ~hs_act;
        VSYNC_in = ~vs_act;
        exp_q.push_back({o, hs_act, vs_act, hs_act & ~prev_hs, vs_act & ~prev_vs});
        prev_hs = hs_act;
        prev_vs = vs_act;
        vcyc++;
        px++;
        if (px >= this_len) begin
            px = 0;
            ln++;
            if (ln >= frame_lines) ln = 0;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_to(input int l, input int p);
        int n;
        n = 0;
        step();
        n++;
        while (!(ln == l && px == p) && n < 5000) begin
            step();
            n++;
        end
        if (n >= 5000) begin
            n_checks++;
            n_errors++;
            $display("FAIL run_to: position %0d/%0d not reached in 5000 cycles", l, p);
        end
    endtask

    task automatic idle_inputs();
        R_in = '0; G_in = '0; B_in = '0; F_in = '0;
        HSYNC_in = 1'b1;
        VSYNC_in = 1'b1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        mon_en  = 1'b0;
        idle_inputs();
        repeat (3) @(negedge PCLK);
        exp_q.delete();
        prev_hs = 1'b0;
        prev_vs = 1'b0;
        px = 0;
        ln = 0;
        reset_n = 1'b1;
        mon_en  = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_colour"}, {8'h0, R_out, G_out, B_out}, 32'h0);
        check({tag, "_sync"}, {28'h0, HSYNC_out, VSYNC_out, hsync_edge, vsync_edge}, 32'h0);
        check({tag, "_cnt"}, {9'h0, hcnt, vcnt}, 32'h0);
        check({tag, "_total"}, {9'h0, h_total, v_total}, 32'h0);
        check({tag, "_locked"}, {31'h0, locked}, 32'h0);
    endtask

    // ---------------- scoreboard monitor ----------------
    initial begin
        logic [27:0] e;
        forever begin
            @(posedge PCLK);
            #2;
            if (mon_en && exp_q.size() >= 2) begin
                e = exp_q.pop_front();
                check("pixel_sync", {4'h0, R_out, G_out, B_out, HSYNC_out, VSYNC_out,
                                     hsync_edge, vsync_edge}, {4'h0, e});
                if (e[1]) check("hcnt_at_hedge", {20'h0, hcnt}, 32'h0);
                if (e[0]) check("vcnt_at_vedge", {21'h0, vcnt}, 32'h0);
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        reset_n = 1'b0;
        idle_inputs();
        repeat (2) @(negedge PCLK);
        check_all_zero("por");
        do_reset();

        // Reference frame, first measured frame, then three matching frames
        run(4 * 400);
        check("lock_early", {31'h0, locked}, 32'h0);
        check("h_total_40", {20'h0, h_total}, 32'd40);
        check("v_total_10", {21'h0, v_total}, 32'd10);
        run(3);
        check("frame_hedge", {31'h0, hsync_edge}, 32'h1);
        check("frame_vedge", {31'h0, vsync_edge}, 32'h1);
        check("frame_hcnt0", {20'h0, hcnt}, 32'h0);
        check("frame_vcnt0", {21'h0, vcnt}, 32'h0);
        check("lock_not_yet", {31'h0, locked}, 32'h0);
        run(1);
        check("lock_rise", {31'h0, locked}, 32'h1);

        // One line of 41 clocks: within tolerance, lock held
        run_to(0, 0);
        ovr_line = 3;
        ovr_len  = 41;
        run_to(0, 0);
        check("lock_held_41", {31'h0, locked}, 32'h1);
        check("h_total_after_41", {20'h0, h_total}, 32'd40);
        check("v_total_after_41", {21'h0, v_total}, 32'd10);

        // One line of 43 clocks: out of tolerance, lock falls
        ovr_len = 43;
        run_to(4, 0);
        ovr_line = -1;
        run(3);
        check("lock_before_drop", {31'h0, locked}, 32'h1);
        check("h_total_before_43", {20'h0, h_total}, 32'd40);
        run(1);
        check("lock_drop_43", {31'h0, locked}, 32'h0);
        check("h_total_43", {20'h0, h_total}, 32'd43);

        // Relock: one edge to enter tracking, then three matching frames
        run_to(0, 0);
        run(3 * 400 + 3);
        check("relock_early", {31'h0, locked}, 32'h0);
        run(1);
        check("relock", {31'h0, locked}, 32'h1);

        // Sync loss: hcnt saturates, h_total kept, lock lost
        run_to(2, 0);
        run(5);
        hs_en = 1'b0;
        vs_en = 1'b0;
        run(4000);
        check("hcnt_running", {20'h0, hcnt}, 32'd4002);
        check("lock_before_ovf", {31'h0, locked}, 32'h1);
        run(200);
        check("hcnt_saturated", {20'h0, hcnt}, 32'hFFF);
        check("lock_ovf_drop", {31'h0, locked}, 32'h0);
        check("h_total_kept", {20'h0, h_total}, 32'd40);

        // Restore syncs and relock
        px = 0;
        ln = 0;
        hs_en = 1'b1;
        vs_en = 1'b1;
        run(6 * 400);
        check("lock_restored", {31'h0, locked}, 32'h1);
        check("h_total_restored", {20'h0, h_total}, 32'd40);
        check("v_total_restored", {21'h0, v_total}, 32'd10);

        // Asynchronous reset mid-frame while locked
        run_to(5, 7);
        #3;
        reset_n = 1'b0;
        mon_en  = 1'b0;
        #1;
        check_all_zero("mid_rst");
        do_reset();
        run(20);
        check("post_rst_h_total", {20'h0, h_total}, 32'h0);
        check("post_rst_v_total", {21'h0, v_total}, 32'h0);
        run(4 * 400 - 20 + 3);
        check("post_rst_lock_early", {31'h0, locked}, 32'h0);
        run(1);
        check("post_rst_lock", {31'h0, locked}, 32'h1);

        repeat (3) @(negedge PCLK);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
